// File: rtl/reset_pkg.sv
// Shared state encoding and default timing constants for the reset sequencer.
package reset_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT   = 2'd0,
    ST_WAIT_ACK = 2'd1,
    ST_RELEASE  = 2'd2,
    ST_RUN      = 2'd3
  } state_t;

  localparam int DEF_N_DOMAINS       = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_MIN_PULSE       = 8;
  localparam int DEF_RELEASE_GAP     = 4;
  localparam int DEF_ACK_TIMEOUT     = 64;

  // One spare bit over the limit so a terminal count always fits.
  function automatic int cnt_width(input int limit);
    return $clog2(limit) + 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchronizer followed by a stability
// counter; btn_stable only follows the input after it has held a new value
// for DEBOUNCE_CYCLES consecutive samples.
module btn_debounce
  import reset_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_stable
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          btn_meta;
  logic          btn_sync;
  logic [CW-1:0] cnt;

  // Bring the raw button into the clk domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      btn_meta <= btn_in;
      btn_sync <= btn_meta;
    end
  end

  // Count consecutive disagreeing samples; accept the new level at terminal count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      btn_stable <= 1'b0;
    end else if (btn_sync == btn_stable) begin
      cnt <= '0;
    end else if (cnt >= CNT_LAST) begin
      btn_stable <= btn_sync;
      cnt        <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/reset_seq.sv
// Reset sequencer: holds every downstream domain in reset for a minimum
// pulse, waits for each domain to echo its reset, then releases domains in
// index order with a fixed gap before declaring the system ready.
//
//   state       | meaning
//   ------------+---------------------------------------------------------
//   ST_ASSERT   | all rst_req high, timing the minimum reset pulse
//   ST_WAIT_ACK | all rst_req high, waiting for every domain ack (bounded)
//   ST_RELEASE  | clearing rst_req bits in index order, RELEASE_GAP apart
//   ST_RUN      | all domains out of reset, sys_ready high
module reset_seq
  import reset_pkg::*;
#(
  parameter int N_DOMAINS       = DEF_N_DOMAINS,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int MIN_PULSE       = DEF_MIN_PULSE,
  parameter int RELEASE_GAP     = DEF_RELEASE_GAP,
  parameter int ACK_TIMEOUT     = DEF_ACK_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 btn_in,
  input  logic                 sw_rst_req,
  input  logic [N_DOMAINS-1:0] dom_ack,
  output logic [N_DOMAINS-1:0] rst_req,
  output logic                 sys_ready,
  output logic                 timeout_err
);

  localparam int PW = cnt_width(MIN_PULSE);
  localparam int AW = cnt_width(ACK_TIMEOUT);
  localparam int GW = cnt_width(RELEASE_GAP);
  localparam int IW = cnt_width(N_DOMAINS);

  localparam logic [PW-1:0] PULSE_LAST = PW'(MIN_PULSE - 1);
  localparam logic [AW-1:0] ACK_LAST   = AW'(ACK_TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(RELEASE_GAP - 1);
  localparam logic [IW-1:0] IDX_END    = IW'(N_DOMAINS);

  logic                 btn_stable;
  logic                 btn_stable_q;
  logic                 trigger;
  logic [N_DOMAINS-1:0] ack_meta;
  logic [N_DOMAINS-1:0] ack_sync;
  logic                 ack_all;

  state_t               state_q,     state_d;
  logic [PW-1:0]        pulse_cnt_q, pulse_cnt_d;
  logic [AW-1:0]        ack_cnt_q,   ack_cnt_d;
  logic [GW-1:0]        gap_cnt_q,   gap_cnt_d;
  logic [IW-1:0]        rel_idx_q,   rel_idx_d;
  logic [N_DOMAINS-1:0] rst_req_d;
  logic                 sys_ready_d;
  logic                 timeout_d;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk        (clk),
    .rst        (rst),
    .btn_in     (btn_in),
    .btn_stable (btn_stable)
  );

  // Synchronize domain acks and remember the last debounced button level.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_meta     <= '0;
      ack_sync     <= '0;
      btn_stable_q <= 1'b0;
    end else begin
      ack_meta     <= dom_ack;
      ack_sync     <= ack_meta;
      btn_stable_q <= btn_stable;
    end
  end

  // Only a press (rising debounced edge) requests a reset, not a release.
  assign trigger = (btn_stable & ~btn_stable_q) | sw_rst_req;
  assign ack_all = &ack_sync;

  // State, counters and all outputs are registered together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ASSERT;
      pulse_cnt_q <= '0;
      ack_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      rel_idx_q   <= '0;
      rst_req     <= '1;
      sys_ready   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      pulse_cnt_q <= pulse_cnt_d;
      ack_cnt_q   <= ack_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      rel_idx_q   <= rel_idx_d;
      rst_req     <= rst_req_d;
      sys_ready   <= sys_ready_d;
      timeout_err <= timeout_d;
    end
  end

  // Next-state and next-output logic; counters stop at their terminal count.
  always_comb begin
    state_d     = state_q;
    pulse_cnt_d = pulse_cnt_q;
    ack_cnt_d   = ack_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    rel_idx_d   = rel_idx_q;
    rst_req_d   = rst_req;
    timeout_d   = timeout_err;

    if (trigger && state_q != ST_ASSERT) begin
      state_d     = ST_ASSERT;
      rst_req_d   = '1;
      pulse_cnt_d = '0;
      ack_cnt_d   = '0;
      gap_cnt_d   = '0;
      rel_idx_d   = '0;
    end else begin
      case (state_q)
        ST_ASSERT: begin
          rst_req_d = '1;
          if (trigger) begin
            pulse_cnt_d = '0;
          end else if (pulse_cnt_q >= PULSE_LAST) begin
            state_d     = ST_WAIT_ACK;
            pulse_cnt_d = '0;
            ack_cnt_d   = '0;
          end else begin
            pulse_cnt_d = pulse_cnt_q + 1'b1;
          end
        end
        ST_WAIT_ACK: begin
          rst_req_d = '1;
          if (ack_all || ack_cnt_q >= ACK_LAST) begin
            // A timeout still releases; the sticky flag records it.
            if (!ack_all) timeout_d = 1'b1;
            state_d      = ST_RELEASE;
            rst_req_d[0] = 1'b0;
            rel_idx_d    = IW'(1);
            gap_cnt_d    = '0;
            ack_cnt_d    = '0;
          end else begin
            ack_cnt_d = ack_cnt_q + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (rel_idx_q >= IDX_END) begin
            state_d = ST_RUN;
          end else if (gap_cnt_q >= GAP_LAST) begin
            for (int i = 1; i < N_DOMAINS; i++) begin
              if (rel_idx_q == IW'(i)) rst_req_d[i] = 1'b0;
            end
            rel_idx_d = rel_idx_q + 1'b1;
            gap_cnt_d = '0;
          end else begin
            gap_cnt_d = gap_cnt_q + 1'b1;
          end
        end
        ST_RUN: begin
          rst_req_d = '0;
        end
        default: begin
          state_d   = ST_ASSERT;
          rst_req_d = '1;
        end
      endcase
    end

    sys_ready_d = (state_d == ST_RUN);
  end

endmodule

// File: tb/tb_reset_seq.sv
// Directed bench for reset_seq: expectations are queued as each step is set
// up and popped in order as the DUT response is observed.
module tb_reset_seq;
  import reset_pkg::*;

  localparam int N           = 2;
  localparam int DEBOUNCE    = 16;
  localparam int MIN_PULSE   = 8;
  localparam int RELEASE_GAP = 4;
  localparam int ACK_TIMEOUT = 64;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         btn_in = 1'b0;
  logic         sw_rst_req = 1'b0;
  logic [N-1:0] dom_ack;
  logic [N-1:0] rst_req;
  logic         sys_ready;
  logic         timeout_err;

  logic         ack_mode = 1'b1;
  logic [N-1:0] ack_pipe [5] = '{default: '0};

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  reset_seq #(
    .N_DOMAINS       (N),
    .DEBOUNCE_CYCLES (DEBOUNCE),
    .MIN_PULSE       (MIN_PULSE),
    .RELEASE_GAP     (RELEASE_GAP),
    .ACK_TIMEOUT     (ACK_TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_in      (btn_in),
    .sw_rst_req  (sw_rst_req),
    .dom_ack     (dom_ack),
    .rst_req     (rst_req),
    .sys_ready   (sys_ready),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  // Domains echo their reset request five clocks later (or never, if ack_mode is 0).
  always @(posedge clk) begin
    ack_pipe[0] <= rst_req;
    for (int i = 1; i < 5; i++) ack_pipe[i] <= ack_pipe[i-1];
  end
  assign dom_ack = ack_mode ? ack_pipe[4] : '0;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end of test, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check_next(input logic [31:0] obs);
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: observed %0h, required a queued expectation", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.val) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", e.tag, obs, e.val);
    end
  endtask

  // Called at a negedge; leaves sw_rst_req low after n clock edges.
  task automatic pulse_sw(input int n);
    sw_rst_req = 1'b1;
    repeat (n) @(negedge clk);
    sw_rst_req = 1'b0;
  endtask

  // Follows one sequence from the current sample: length of the all-ones
  // phase, release of domain 0 first, gap to domain 1, then sys_ready.
  task automatic seq_check(input string tag, input int lo, input int hi_max, input logic exp_to);
    int hi;
    int gap;
    expect_val({tag, "_assert_len_ok"}, 32'd1);
    expect_val({tag, "_first_release"}, 32'h2);
    expect_val({tag, "_timeout_err"}, {31'd0, exp_to});
    expect_val({tag, "_release_gap"}, RELEASE_GAP);
    expect_val({tag, "_ready_before_run"}, 32'd0);
    expect_val({tag, "_ready_in_run"}, 32'd1);
    expect_val({tag, "_run_rst_req"}, 32'd0);
    hi = 0;
    while (rst_req === 2'b11 && hi < 300) begin
      hi++;
      @(negedge clk);
    end
    check_next({31'd0, (hi >= lo && hi <= hi_max)});
    check_next({30'd0, rst_req});
    check_next({31'd0, timeout_err});
    gap = 0;
    while (rst_req !== 2'b00 && gap < 50) begin
      gap++;
      @(negedge clk);
    end
    check_next(gap);
    check_next({31'd0, sys_ready});
    @(negedge clk);
    check_next({31'd0, sys_ready});
    check_next({30'd0, rst_req});
  endtask

  initial begin
    int  drops;
    int  c;
    logic found;

    // Power-on reset held for three cycles.
    expect_val("reset_rst_req", 32'h3);
    expect_val("reset_sys_ready", 32'd0);
    expect_val("reset_timeout_err", 32'd0);
    expect_val("reset_state_assert", 32'd1);
    repeat (3) @(negedge clk);
    check_next({30'd0, rst_req});
    check_next({31'd0, sys_ready});
    check_next({31'd0, timeout_err});
    check_next({31'd0, (dut.state_q === ST_ASSERT)});
    rst = 1'b0;
    seq_check("por", MIN_PULSE, 100, 1'b0);
    repeat (5) @(negedge clk);

    // Bouncing button never holds long enough to be accepted.
    expect_val("bounce_ready_drops", 32'd0);
    expect_val("bounce_rst_req", 32'd0);
    drops = 0;
    for (int i = 0; i < 60; i++) begin
      btn_in = ((i / 5) % 2 == 0);
      @(negedge clk);
      if (sys_ready !== 1'b1) drops++;
    end
    btn_in = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sys_ready !== 1'b1) drops++;
    end
    check_next(drops);
    check_next({30'd0, rst_req});

    // Steady press starts a sequence within 19 cycles.
    expect_val("btn_hold_asserts", 32'd1);
    btn_in = 1'b1;
    found = 1'b0;
    c = 0;
    while (!found && c < 19) begin
      @(negedge clk);
      c++;
      if (rst_req === 2'b11) found = 1'b1;
    end
    check_next({31'd0, found});
    repeat (20 - c) @(negedge clk);
    btn_in = 1'b0;
    seq_check("btn", 1, 100, 1'b0);
    repeat (30) @(negedge clk);

    // Domains never ack: 8 ASSERT + 64 WAIT_ACK samples of all-ones, then
    // release with timeout_err; 69 of the 72 are consumed before seq_check.
    ack_mode = 1'b0;
    repeat (8) @(negedge clk);
    expect_val("timeout_not_early", 32'd0);
    pulse_sw(1);
    repeat (69) @(negedge clk);
    check_next({31'd0, timeout_err});
    seq_check("timeout", 3, 3, 1'b1);
    repeat (8) @(negedge clk);
    ack_mode = 1'b1;
    repeat (8) @(negedge clk);

    // A new sequence leaves the sticky flag set.
    pulse_sw(1);
    seq_check("retrig", MIN_PULSE, 100, 1'b1);
    repeat (8) @(negedge clk);

    // Trigger one cycle after domain 0 is released restarts everything.
    expect_val("mid_first_release", 32'h2);
    expect_val("mid_reassert", 32'h3);
    pulse_sw(1);
    c = 0;
    while (rst_req === 2'b11 && c < 300) begin
      c++;
      @(negedge clk);
    end
    check_next({30'd0, rst_req});
    @(negedge clk);
    sw_rst_req = 1'b1;
    @(negedge clk);
    sw_rst_req = 1'b0;
    check_next({30'd0, rst_req});
    seq_check("mid", MIN_PULSE, 100, 1'b1);
    repeat (8) @(negedge clk);

    // Two-cycle request: pulse timer restarts once, so 8 ASSERT cycles plus
    // one WAIT_ACK cycle are seen after the pulse ends (8 without restart).
    pulse_sw(2);
    seq_check("b2b", MIN_PULSE + 1, MIN_PULSE + 1, 1'b1);
    repeat (8) @(negedge clk);

    // rst while waiting for acks returns to ASSERT and clears the flag.
    ack_mode = 1'b0;
    repeat (8) @(negedge clk);
    expect_val("pre_rst_timeout_err", 32'd1);
    expect_val("pre_rst_state_wait_ack", 32'd1);
    expect_val("rst_state_assert", 32'd1);
    expect_val("rst_timeout_err", 32'd0);
    expect_val("rst_rst_req", 32'h3);
    expect_val("rst_sys_ready", 32'd0);
    pulse_sw(1);
    repeat (20) @(negedge clk);
    check_next({31'd0, timeout_err});
    check_next({31'd0, (dut.state_q === ST_WAIT_ACK)});
    rst = 1'b1;
    @(negedge clk);
    check_next({31'd0, (dut.state_q === ST_ASSERT)});
    check_next({31'd0, timeout_err});
    check_next({30'd0, rst_req});
    check_next({31'd0, sys_ready});
    rst = 1'b0;
    ack_mode = 1'b1;
    seq_check("post_rst", MIN_PULSE, 100, 1'b0);

    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover: observed %0d unchecked entries, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reset_seq.md
RESET_SEQ -- requirements
Module: reset_seq

Interface
REQ-001 SHALL have parameter N_DOMAINS, default 2, number of downstream reset domains (index 0 = write domain, 1 = read domain).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 16, stable-input cycles before btn_in change is accepted.
REQ-003 SHALL have parameter MIN_PULSE, default 8, minimum cycles all rst_req held high.
REQ-004 SHALL have parameter RELEASE_GAP, default 4, cycles between successive domain releases.
REQ-005 SHALL have parameter ACK_TIMEOUT, default 64, maximum WAIT_ACK cycles.
REQ-006 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have port btn_in, input, 1, raw asynchronous push-button reset request, active-high.
REQ-009 SHALL have port sw_rst_req, input, 1, single-cycle software reset request, synchronous to clk.
REQ-010 SHALL have port dom_ack, input, N_DOMAINS, per-domain echo of that domain's synchronized reset (asynchronous to clk).
REQ-011 SHALL have port rst_req, output, N_DOMAINS, registered per-domain reset level, feeding each domain's reset synchronizer.
REQ-012 SHALL have port sys_ready, output, 1, high only in RUN.
REQ-013 SHALL have port timeout_err, output, 1, sticky flag, set on ack timeout.

Function
REQ-014 SHALL pass btn_in and each dom_ack bit through a two-flop synchronizer before any use.
REQ-015 SHALL debounce synchronized btn_in: counter clears when sample equals stable value, else increments; stable value updates when counter reaches DEBOUNCE_CYCLES-1.
REQ-016 SHALL generate trigger on rising edge of debounced btn or on sw_rst_req high.
REQ-017 SHALL implement FSM states ASSERT, WAIT_ACK, RELEASE, RUN.
REQ-018 ASSERT: rst_req all ones; pulse counter counts to MIN_PULSE-1, then -> WAIT_ACK.
REQ-019 WAIT_ACK: rst_req all ones; -> RELEASE when all synchronized acks high; if ACK_TIMEOUT cycles elapse first, set timeout_err and -> RELEASE.
REQ-020 RELEASE: clear rst_req[0] on entry, then clear each next index RELEASE_GAP cycles after the previous; -> RUN one cycle after rst_req[N_DOMAINS-1] clears.
REQ-021 RUN: rst_req all zero, sys_ready high; trigger -> ASSERT, rst_req all ones next cycle.
REQ-022 Trigger in ASSERT SHALL restart pulse counter; trigger in WAIT_ACK or RELEASE SHALL -> ASSERT with rst_req all ones and counters cleared.
REQ-023 rst_req bits SHALL never re-assert out of index order during RELEASE; once cleared, a bit stays clear until ASSERT.
REQ-024 timeout_err SHALL clear only on rst, never on re-triggered sequences.
REQ-025 Counters SHALL be sized $clog2 of their limit +1 and SHALL saturate, never wrap.

Reset
REQ-026 While rst high: state ASSERT, rst_req all ones, sys_ready 0, timeout_err 0, all counters 0, synchronizer flops 0, debounced stable value 0.
REQ-027 After rst deasserts the full sequence SHALL run automatically (power-on sequence).
REQ-028 rst asserted mid-sequence SHALL take effect on the next clock edge regardless of state.

Structure
REQ-029 FSM state encoding and default parameter constants SHALL live in shared package reset_pkg.
REQ-030 Debouncer SHALL be one sub-module, btn_debounce (sync, counter, stable output).

Verification
REQ-031 Power-on: rst 3 cycles, dom_ack follows rst_req after 5 cycles -> rst_req=2'b11 ≥8 cycles, rst_req[0] clears, rst_req[1] clears 4 cycles later, sys_ready 1 next cycle.
REQ-032 Bounce: btn_in toggles every 5 cycles for 60 cycles then low -> no trigger, sys_ready stays 1; btn_in held high 20 cycles -> rst_req=2'b11 within 19 cycles.
REQ-033 Timeout: dom_ack tied 0 -> after 64 WAIT_ACK cycles timeout_err=1, release proceeds, sys_ready 1; second trigger keeps timeout_err=1.
REQ-034 Mid-release trigger: sw_rst_req pulse 1 cycle after rst_req[0] clears -> rst_req=2'b11 next cycle, full sequence repeats.
REQ-035 Back-to-back: sw_rst_req high 2 cycles in RUN -> single sequence, ASSERT pulse counter restarted, release order 0 then 1.
REQ-036 rst in WAIT_ACK -> next edge state ASSERT, timeout_err 0, rst_req=2'b11.
